uart_tx_ctrl: RTL and testbench

UART transmit controller: accepts a parallel byte over a valid/ready handshake and serialises it onto the tx line.
- Frame: start bit, DATA_W data bits LSB-first, optional parity bit, one stop bit.
- Bit timing comes from an internal baud-period counter used as a clock enable. No derived clock.
- The block is the bit-level sequencer between host-side logic and the UART pin, and shares clk with the rest of the UART.

---
 rtl/uart_tx_ctrl.sv | 134 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: valid/ready byte in, start + DATA_W bits LSB-first + stop out.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_ctrl #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int IDX_W    = $clog2(DATA_W);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    logic [2:0]        state;
    logic [CNT_W-1:0]  baud_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift;
    logic              bit_end;
`ifdef UART_PARITY_EN
    logic              parity;
`endif

    assign bit_end = (baud_cnt == CNT_LAST);

    // Baud counter acts as the bit-rate enable; it only runs while a frame is active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
        end else if (state == IDLE || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef UART_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A non-1 tx_valid (0 or X) falls through and keeps the line idle.
                    if (tx_valid && tx_ready) begin
                        state    <= START;
                        shift    <= tx_data;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef UART_PARITY_EN
                        parity   <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx      <= shift[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                            state <= PARITY;
                            tx    <= parity;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            tx <= shift[1];
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl at BAUD_DIV=8, DATA_W=8; parity scenarios
// run only when UART_PARITY_EN is defined.
module tb_uart_tx_ctrl;

    localparam int BD = 8;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_ctrl #(.CLK_FREQ(8), .BAUD(1), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for ready, present a byte and clock the transfer edge; leaves time at edge+1.
    task automatic send(input logic [7:0] d, input logic hold);
        int w = 0;
        while (tx_ready !== 1'b1 && w < 200) begin
            tick();
            w++;
        end
        chk("ready_before_send", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        if (!hold) tx_valid = 1'b0;
    endtask

    // Called at transfer edge + 1; checks every cycle of the frame and the done cycle.
    task automatic frame_check(input logic [7:0] d, input int chg_at, input logic [7:0] chg_val);
        logic [FB-1:0] bits;
`ifdef UART_PARITY_EN
        bits = {1'b1, ^d, d, 1'b0};
`else
        bits = {1'b1, d, 1'b0};
`endif
        for (int c = 0; c < FB*BD; c++) begin
            if (c == chg_at) tx_data = chg_val;
            chk($sformatf("tx_%02h_bit%0d_c%0d", d, c/BD, c), 32'(tx), 32'(bits[c/BD]));
            chk($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
            chk($sformatf("ready_c%0d", c), 32'(tx_ready), 32'd0);
            chk($sformatf("done_c%0d", c), 32'(done), 32'd0);
            tick();
        end
        chk("done_at_end", 32'(done), 32'd1);
        chk("busy_at_end", 32'(busy), 32'd0);
        chk("ready_at_end", 32'(tx_ready), 32'd1);
        chk("tx_at_end", 32'(tx), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;

        // 1. Reset and idle line
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        chk("post_rst_tx", 32'(tx), 32'd1);
        chk("post_rst_ready", 32'(tx_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        chk("idle_50_cycles", 32'(bad), 32'd0);

        // 2. Single byte 0xA5; done must be a one-cycle pulse
        send(8'hA5, 1'b0);
        frame_check(8'hA5, -1, 8'h00);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done_tx", 32'(tx), 32'd1);

        // 3. Back-to-back 0x00 then 0xFF with tx_valid held
        send(8'h00, 1'b1);
        frame_check(8'h00, 0, 8'hFF);
        tick();
        tx_valid = 1'b0;
        chk("b2b_start_after_one_idle", 32'(tx), 32'd0);
        frame_check(8'hFF, -1, 8'h00);
        tick();

        // 4. Data change mid-frame is ignored
        send(8'h3C, 1'b0);
        frame_check(8'h3C, 20, 8'hFF);
        tick();

        // 5a. Reset during data bit 3 of 0x0F
        send(8'h0F, 1'b0);
        repeat (34) @(posedge clk);
        #3;
        chk("pre_rst_tx_bit3", 32'(tx), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ready", 32'(tx_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done !== 1'b0 || tx !== 1'b1) bad++;
        end
        chk("no_done_after_abort", 32'(bad), 32'd0);
        rst = 1'b1;
        send(8'h55, 1'b0);
        frame_check(8'h55, -1, 8'h00);
        tick();

        // 5b. Reset while the line is low must raise tx without a clock edge
        send(8'h00, 1'b0);
        repeat (20) @(posedge clk);
        #3;
        chk("pre_rst_tx_low", 32'(tx), 32'd0);
        rst = 1'b0;
        #1;
        chk("async_rst_tx_rise", 32'(tx), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("idle_after_rst_ready", 32'(tx_ready), 32'd1);

`ifdef UART_PARITY_EN
        // 6. Parity bit: 0x07 -> 1, 0x03 -> 0; done at 88 cycles
        send(8'h07, 1'b0);
        frame_check(8'h07, -1, 8'h00);
        tick();
        send(8'h03, 1'b0);
        frame_check(8'h03, -1, 8'h00);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
